// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: access sizes, data-memory FSM states
// and the lane/extend helpers used by the data-memory responder.
package mips_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } dmem_state_t;

    typedef struct packed {
        logic       we;
        logic [1:0] size;
        logic [1:0] lo;
        logic       uns;
    } dmem_ctl_t;

    function automatic logic isMisaligned(
        input logic [1:0] size,
        input logic [1:0] lo
    );
        logic m;
        m = 1'b0;
        unique case (size)
            SZ_BYTE: m = 1'b0;
            SZ_HALF: m = lo[0];
            default: m = |lo;
        endcase
        return m;
    endfunction

    function automatic logic [3:0] byteEnable(
        input logic [1:0] size,
        input logic [1:0] lo
    );
        logic [3:0] be;
        be = 4'b1111;
        unique case (size)
            SZ_BYTE: be = 4'b0001 << lo;
            SZ_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate narrow store data so every enabled lane sees it
    function automatic logic [31:0] laneData(
        input logic [1:0]  size,
        input logic [31:0] wd
    );
        logic [31:0] d;
        d = wd;
        unique case (size)
            SZ_BYTE: d = {4{wd[7:0]}};
            SZ_HALF: d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] loadExtend(
        input logic [31:0] q,
        input logic [1:0]  size,
        input logic [1:0]  lo,
        input logic        uns
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = q[{lo, 3'b000} +: 8];
        h = lo[1] ? q[31:16] : q[15:0];
        r = q;
        unique case (size)
            SZ_BYTE: r = {{24{~uns & b[7]}}, b};
            SZ_HALF: r = {{16{~uns & h[15]}}, h};
            default: r = q;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with four byte-enable lanes and a
// registered (one-cycle) read port; contents are never reset.
module dmem_array #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] idx,
    input  logic [31:0]       wdata,
    output logic [31:0]       q
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                q <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target for the MEM stage: latches a load/store, waits
// WAIT_CYC cycles, accesses the RAM and answers with an ack pulse.
module dmem_responder
    import mips_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int WAIT_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        stall,
    output logic        misalign
);

    localparam logic [3:0] CNT_LOAD =
        4'(WAIT_CYC > 0 ? WAIT_CYC - 1 : 0);

    dmem_state_t       state;
    dmem_state_t       nextState;
    logic [3:0]        cnt;
    logic [3:0]        nextCnt;
    logic              accept;
    logic              reqMis;

    dmem_ctl_t         ctlQ;
    logic [ADDR_W-1:0] idxQ;
    logic [31:0]       wdataQ;

    logic              ramEn;
    logic [3:0]        ramBe;
    logic [31:0]       ramWdata;
    logic [31:0]       ramQ;
    logic [31:0]       loadVal;

    logic              ackQ;
    logic              misQ;
    logic [31:0]       rdataQ;

    // Address bits above the RAM index wrap the array
    logic              unusedAddrBits;
    assign unusedAddrBits = ^addr[31:ADDR_W+2];

    assign accept = (state == IDLE) && req;
    assign reqMis = isMisaligned(size, addr[1:0]);

    always_comb begin
        nextState = state;
        nextCnt   = cnt;
        unique case (state)
            IDLE: begin
                if (req) begin
                    if (reqMis) begin
                        nextState = RESP;
                    end else if (WAIT_CYC == 0) begin
                        nextState = ACCESS;
                    end else begin
                        nextState = WAIT;
                        nextCnt   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    nextState = ACCESS;
                end else begin
                    nextCnt = cnt - 4'd1;
                end
            end
            ACCESS: nextState = RESP;
            RESP:   nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= nextState;
            cnt   <= nextCnt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctlQ   <= '0;
            idxQ   <= '0;
            wdataQ <= '0;
        end else if (accept) begin
            ctlQ.we   <= we;
            ctlQ.size <= size;
            ctlQ.lo   <= addr[1:0];
            ctlQ.uns  <= uns;
            idxQ      <= addr[ADDR_W+1:2];
            wdataQ    <= wdata;
        end
    end

    assign ramEn    = (state == ACCESS);
    assign ramBe    = byteEnable(ctlQ.size, ctlQ.lo);
    assign ramWdata = laneData(ctlQ.size, wdataQ);

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) uArray (
        .clk   (clk),
        .en    (ramEn),
        .we    (ctlQ.we),
        .be    (ramBe),
        .idx   (idxQ),
        .wdata (ramWdata),
        .q     (ramQ)
    );

    assign loadVal = loadExtend(ramQ, ctlQ.size, ctlQ.lo, ctlQ.uns);

    // Only a misaligned request jumps straight from IDLE to RESP
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ackQ   <= 1'b0;
            misQ   <= 1'b0;
            rdataQ <= '0;
        end else begin
            ackQ <= (nextState == RESP);
            misQ <= (state == IDLE) && (nextState == RESP);
            if (ackQ) begin
                rdataQ <= rdata;
            end
        end
    end

    // Load data comes straight off the RAM in RESP, then is held
    always_comb begin
        rdata = rdataQ;
        if (ackQ && !ctlQ.we) begin
            rdata = misQ ? '0 : loadVal;
        end
    end

    assign ack      = ackQ;
    assign misalign = misQ;
    assign stall    = req & ~ackQ;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed and random accesses checked
// against a byte-addressed memory model, on two latency settings.
module tb_dmem_responder;
    import mips_pkg::*;

    localparam int WAIT0 = 2;
    localparam int WAIT1 = 0;
    localparam int MEMB  = 4096;

    logic        clk;
    logic        rst      [2];
    logic        req      [2];
    logic        we       [2];
    logic [31:0] addr     [2];
    logic [31:0] wdata    [2];
    logic [1:0]  size     [2];
    logic        uns      [2];
    logic [31:0] rdata    [2];
    logic        ack      [2];
    logic        stall    [2];
    logic        misalign [2];

    logic [7:0]  mem   [2][MEMB];
    logic [31:0] expRd [2];

    int nAsserts;
    int nFail;

    dmem_responder #(.ADDR_W(10), .WAIT_CYC(WAIT0)) u0 (
        .clk(clk), .rst(rst[0]), .req(req[0]), .we(we[0]),
        .addr(addr[0]), .wdata(wdata[0]), .size(size[0]),
        .uns(uns[0]), .rdata(rdata[0]), .ack(ack[0]),
        .stall(stall[0]), .misalign(misalign[0])
    );

    dmem_responder #(.ADDR_W(10), .WAIT_CYC(WAIT1)) u1 (
        .clk(clk), .rst(rst[1]), .req(req[1]), .we(we[1]),
        .addr(addr[1]), .wdata(wdata[1]), .size(size[1]),
        .uns(uns[1]), .rdata(rdata[1]), .ack(ack[1]),
        .stall(stall[1]), .misalign(misalign[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int waitOf(input int d);
        return (d == 0) ? WAIT0 : WAIT1;
    endfunction

    function automatic int nBytes(input logic [1:0] sz);
        return (sz == SZ_BYTE) ? 1 : (sz == SZ_HALF) ? 2 : 4;
    endfunction

    function automatic logic modelMis(input logic [31:0] a, input logic [1:0] sz);
        return (a % nBytes(sz)) != 0;
    endfunction

    function automatic logic [31:0] modelLoad(input int d, input logic [31:0] a,
                                              input logic [1:0] sz, input logic u);
        int base;
        int n;
        logic [31:0] v;
        base = int'(a % MEMB);
        n = nBytes(sz);
        v = 0;
        for (int i = 0; i < n; i++) v = v | (32'(mem[d][base+i]) << (8 * i));
        if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8 * n));
        return v;
    endfunction

    task automatic modelStore(input int d, input logic [31:0] a,
                              input logic [1:0] sz, input logic [31:0] wd);
        int base;
        base = int'(a % MEMB);
        for (int i = 0; i < nBytes(sz); i++) mem[d][base+i] = wd[8*i +: 8];
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic access(input int d, input logic w, input logic [31:0] a,
                          input logic [31:0] wd, input logic [1:0] sz,
                          input logic u, output logic [31:0] got);
        int lat;
        logic mis;
        @(negedge clk);
        req[d] = 1'b1; we[d] = w; addr[d] = a;
        wdata[d] = wd; size[d] = sz; uns[d] = u;
        #1 check("stallOnReq", 32'(stall[d]), 1);
        mis = modelMis(a, sz);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (!ack[d]) check("stallHeld", 32'(stall[d]), 1);
        end while (!ack[d] && lat < 40);
        check("latency", lat, mis ? 1 : waitOf(d) + 2);
        check("stallAtAck", 32'(stall[d]), 0);
        check("misalign", 32'(misalign[d]), 32'(mis));
        if (!w) expRd[d] = mis ? 32'h0 : modelLoad(d, a, sz, u);
        else if (!mis) modelStore(d, a, sz, wd);
        check("rdata", rdata[d], expRd[d]);
        got = rdata[d];
        req[d] = 1'b0;
        @(negedge clk);
        check("ackPulse", 32'(ack[d]), 0);
        check("rdataHeld", rdata[d], expRd[d]);
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] a;
        logic [1:0]  sz;
        logic        w;
        logic        u;
        int          lat;

        nAsserts = 0;
        nFail = 0;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b0; req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0;
            wdata[d] = '0; size[d] = SZ_WORD; uns[d] = 1'b0; expRd[d] = '0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rstRdata", rdata[d], 0);
            check("rstAck", 32'(ack[d]), 0);
            check("rstMisalign", 32'(misalign[d]), 0);
            check("rstStall", 32'(stall[d]), 0);
        end
        rst[0] = 1'b1;
        rst[1] = 1'b1;

        access(0, 1, 32'h40, 32'hDEADBEEF, SZ_WORD, 0, got);
        access(0, 0, 32'h40, 0, SZ_WORD, 0, got);
        check("lw40", got, 32'hDEADBEEF);
        access(0, 0, 32'h40, 0, SZ_BYTE, 0, got);
        check("lb40", got, 32'hFFFFFFEF);
        access(0, 0, 32'h40, 0, SZ_BYTE, 1, got);
        check("lbu40", got, 32'h000000EF);
        access(0, 0, 32'h42, 0, SZ_HALF, 0, got);
        check("lh42", got, 32'hFFFFDEAD);
        access(0, 0, 32'h42, 0, SZ_HALF, 1, got);
        check("lhu42", got, 32'h0000DEAD);
        access(0, 1, 32'h41, 32'h12345680, SZ_BYTE, 0, got);
        access(0, 0, 32'h40, 0, SZ_WORD, 0, got);
        check("lwAfterSb", got, 32'hDEAD80EF);
        access(0, 0, 32'h42, 0, SZ_WORD, 0, got);
        check("lwMisRdata", got, 32'h0);
        access(0, 1, 32'h43, 32'h55555555, SZ_WORD, 0, got);
        access(0, 0, 32'h40, 0, SZ_WORD, 0, got);
        check("misStoreNoWrite", got, 32'hDEAD80EF);

        access(0, 1, 32'h80, 32'hCAFEF00D, SZ_WORD, 0, got);
        access(0, 0, 32'h80, 0, SZ_WORD, 0, got);
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h80;
        wdata[0] = 32'h11111111; size[0] = SZ_WORD;
        @(posedge clk);
        @(negedge clk);
        check("preRstRdata", rdata[0], 32'hCAFEF00D);
        #2 rst[0] = 1'b0;
        #1;
        check("asyncRdata", rdata[0], 0);
        check("asyncAck", 32'(ack[0]), 0);
        check("asyncMis", 32'(misalign[0]), 0);
        req[0] = 1'b0;
        expRd[0] = '0;
        repeat (2) @(negedge clk);
        rst[0] = 1'b1;
        access(0, 0, 32'h80, 0, SZ_WORD, 0, got);
        check("abortedStore", got, 32'hCAFEF00D);

        access(0, 1, 32'h1000, 32'h0BADCAFE, SZ_WORD, 0, got);
        access(0, 0, 32'h0, 0, SZ_WORD, 0, got);
        check("alias", got, 32'h0BADCAFE);

        for (int k = 0; k < 3; k++)
            access(1, 1, 32'h10 + 32'(4 * k), $urandom, SZ_WORD, 0, got);
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b0; size[1] = SZ_WORD; uns[1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            addr[1] = 32'h10 + 32'(4 * k);
            lat = 0;
            do begin
                @(posedge clk);
                lat++;
                @(negedge clk);
                if (!ack[1]) check("b2bStallHeld", 32'(stall[1]), 1);
            end while (!ack[1] && lat < 20);
            check("b2bLatency", lat, (k == 0) ? 2 : 3);
            check("b2bStallAck", 32'(stall[1]), 0);
            expRd[1] = modelLoad(1, 32'h10 + 32'(4 * k), SZ_WORD, 0);
            check("b2bRdata", rdata[1], expRd[1]);
        end
        req[1] = 1'b0;
        @(negedge clk);
        check("b2bAckDrop", 32'(ack[1]), 0);

        for (int i = 0; i < 64; i++)
            access(0, 1, 32'(4 * i), $urandom, SZ_WORD, 0, got);
        for (int i = 0; i < 80; i++) begin
            a = $urandom;
            a[11:8] = 4'h0;
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == SZ_HALF) a[0] = 1'b0;
                else if (sz != SZ_BYTE) a[1:0] = 2'b00;
            end
            w = 1'($urandom_range(0, 1));
            u = 1'($urandom_range(0, 1));
            access(0, w, a, $urandom, sz, u, got);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
